// File: rtl/acs_select_bank.sv
// Registered NCH-channel metric select / compare-select bank with
// decision bits, valid/ready output stage and common-MSB normalisation.
module acs_select_bank #(
  parameter int W     = 6,
  parameter int NCH   = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NCH*W-1:0]   d0,
  input  logic [NCH*W-1:0]   d1,
  input  logic [NCH-1:0]     sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NCH*W-1:0]   y,
  output logic [NCH-1:0]     dec,
  output logic [CNT_W-1:0]   norm_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic               r_valid;
  logic [NCH*W-1:0]   r_y;
  logic [NCH-1:0]     r_dec;
  logic [CNT_W-1:0]   r_cnt;

  logic [NCH*W-1:0]   w_res;
  logic [NCH*W-1:0]   w_y;
  logic [NCH-1:0]     w_dec;
  logic               w_all_msb;
  logic [W-1:0]       w_c0;
  logic [W-1:0]       w_c1;
  logic               w_acc;

  assign in_ready  = !r_valid || out_ready;
  assign w_acc     = in_valid && in_ready;
  assign out_valid = r_valid;
  assign y         = r_y;
  assign dec       = r_dec;
  assign norm_cnt  = r_cnt;

  always_comb begin
    w_res     = '0;
    w_dec     = '0;
    w_y       = '0;
    w_all_msb = 1'b1;
    w_c0      = '0;
    w_c1      = '0;
    for (int i = 0; i < NCH; i++) begin
      w_c0 = d0[i*W +: W];
      w_c1 = d1[i*W +: W];
      if (mode) w_dec[i] = (w_c1 < w_c0);
      else      w_dec[i] = sel[i];
      w_res[i*W +: W] = w_dec[i] ? w_c1 : w_c0;
      w_all_msb = w_all_msb & w_res[i*W + W - 1];
    end
    // Clearing the shared MSB keeps metric differences intact.
    for (int i = 0; i < NCH; i++) begin
      w_y[i*W +: W] = w_res[i*W +: W];
      if (w_all_msb) w_y[i*W + W - 1] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_y     <= '0;
      r_dec   <= '0;
      r_cnt   <= '0;
    end else if (w_acc) begin
      r_valid <= 1'b1;
      r_y     <= w_y;
      r_dec   <= w_dec;
      if (w_all_msb && r_cnt != CNT_MAX)
        r_cnt <= r_cnt + 1'b1;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acs_select_bank.sv
// Directed bench for acs_select_bank: vector table plus
// saturation, backpressure ordering and mid-stall reset sequences.
module tb_acs_select_bank;
  localparam int W = 6;
  localparam int NCH = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic reset_n, mode, in_valid, in_ready, out_valid, out_ready;
  logic [NCH*W-1:0] d0, d1, y;
  logic [NCH-1:0] sel, dec;
  logic [CNT_W-1:0] norm_cnt;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;
  bit mon_en = 1'b0;
  logic [NCH*W-1:0] got_q[$];

  always #5 clk = ~clk;

  acs_select_bank #(.W(W), .NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready),
    .d0(d0), .d1(d1), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .dec(dec), .norm_cnt(norm_cnt)
  );

  always @(posedge clk)
    if (mon_en && out_valid && out_ready) got_q.push_back(y);

  typedef struct {
    logic             mode;
    logic [NCH-1:0]   sel;
    logic [NCH*W-1:0] d0;
    logic [NCH*W-1:0] d1;
    logic [NCH*W-1:0] ey;
    logic [NCH-1:0]   edec;
    bit               norm;
  } vec_t;

  vec_t tbl[6];

  function automatic logic [NCH*W-1:0] pk(int a, int b, int c, int d);
    logic [5:0] a6, b6, c6, d6;
    a6 = a[5:0]; b6 = b[5:0]; c6 = c[5:0]; d6 = d[5:0];
    return {d6, c6, b6, a6};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic m, logic [NCH-1:0] s,
                       logic [NCH*W-1:0] a, logic [NCH*W-1:0] b);
    mode = m; sel = s; d0 = a; d1 = b;
  endtask

  initial begin
    tbl[0] = '{1'b0, 4'b0101, pk(10,20,30,40), pk(1,2,3,4),
               pk(1,20,3,40), 4'b0101, 1'b0};
    tbl[1] = '{1'b1, 4'b0000, pk(5,9,33,12), pk(7,9,2,63),
               pk(5,9,2,12), 4'b0100, 1'b0};
    tbl[2] = '{1'b1, 4'b1111, pk(40,50,60,63), pk(45,33,61,32),
               pk(8,1,28,0), 4'b1010, 1'b1};
    tbl[3] = '{1'b0, 4'b1111, pk(0,0,0,0), pk(32,33,63,40),
               pk(0,1,31,8), 4'b1111, 1'b1};
    tbl[4] = '{1'b1, 4'b1111, pk(32,40,50,10), pk(63,63,63,63),
               pk(32,40,50,10), 4'b0000, 1'b0};
    tbl[5] = '{1'b1, 4'b0000, pk(63,63,63,63), pk(63,63,63,63),
               pk(31,31,31,31), 4'b0000, 1'b1};

    // reset with live input traffic
    reset_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    drive(1'b1, 4'($urandom), (NCH*W)'($urandom), (NCH*W)'($urandom));
    step(); step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_dec", 64'(dec), 64'd0);
    chk("rst_cnt", 64'(norm_cnt), 64'd0);
    in_valid = 1'b0;
    reset_n = 1'b1;
    step();
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_valid2", 64'(out_valid), 64'd0);

    // table vectors, full throughput
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].mode, tbl[i].sel, tbl[i].d0, tbl[i].d1);
      in_valid = 1'b1;
      step();
      if (tbl[i].norm && exp_cnt < 255) exp_cnt++;
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d_y", i), 64'(y), 64'(tbl[i].ey));
      chk($sformatf("v%0d_dec", i), 64'(dec), 64'(tbl[i].edec));
      chk($sformatf("v%0d_cnt", i), 64'(norm_cnt), 64'(exp_cnt));
    end
    in_valid = 1'b0;
    step();
    chk("drain_valid", 64'(out_valid), 64'd0);

    // counter saturation
    drive(tbl[2].mode, tbl[2].sel, tbl[2].d0, tbl[2].d1);
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (exp_cnt < 255) exp_cnt++;
      if (i == 200) chk("sat_mid", 64'(norm_cnt), 64'(exp_cnt));
    end
    chk("sat_cnt", 64'(norm_cnt), 64'd255);
    in_valid = 1'b0;
    step();
    chk("sat_hold", 64'(norm_cnt), 64'd255);

    // backpressure: A, B, C must emerge once each, in order
    got_q.delete();
    mon_en = 1'b1;
    drive(1'b0, 4'b0000, pk(1,2,3,4), pk(0,0,0,0));
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    drive(1'b0, 4'b0000, pk(5,6,7,8), pk(0,0,0,0));
    out_ready = 1'b0;
    #1;
    chk("bp_ready0", 64'(in_ready), 64'd0);
    step();
    chk("bp_hold_y", 64'(y), 64'(pk(1,2,3,4)));
    chk("bp_hold_v", 64'(out_valid), 64'd1);
    chk("bp_ready1", 64'(in_ready), 64'd0);
    step();
    chk("bp_hold_y2", 64'(y), 64'(pk(1,2,3,4)));
    out_ready = 1'b1;
    step();
    chk("bp_b_y", 64'(y), 64'(pk(5,6,7,8)));
    drive(1'b0, 4'b0000, pk(9,10,11,12), pk(0,0,0,0));
    step();
    chk("bp_c_y", 64'(y), 64'(pk(9,10,11,12)));
    in_valid = 1'b0;
    step();
    chk("bp_drain", 64'(out_valid), 64'd0);
    mon_en = 1'b0;
    chk("bp_count", 64'(got_q.size()), 64'd3);
    if (got_q.size() == 3) begin
      chk("bp_ord0", 64'(got_q[0]), 64'(pk(1,2,3,4)));
      chk("bp_ord1", 64'(got_q[1]), 64'(pk(5,6,7,8)));
      chk("bp_ord2", 64'(got_q[2]), 64'(pk(9,10,11,12)));
    end
    chk("bp_cnt", 64'(norm_cnt), 64'd255);

    // reset while an output beat is stalled
    got_q.delete();
    mon_en = 1'b1;
    drive(tbl[2].mode, tbl[2].sel, tbl[2].d0, tbl[2].d1);
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    step();
    chk("ms_held", 64'(out_valid), 64'd1);
    reset_n = 1'b0;
    step();
    chk("ms_valid", 64'(out_valid), 64'd0);
    chk("ms_y", 64'(y), 64'd0);
    chk("ms_dec", 64'(dec), 64'd0);
    chk("ms_cnt", 64'(norm_cnt), 64'd0);
    reset_n = 1'b1; out_ready = 1'b1;
    step(); step();
    mon_en = 1'b0;
    chk("ms_lost", 64'(got_q.size()), 64'd0);
    chk("ms_valid2", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/acs_select_bank.md
Name: acs_select_bank

Overview:
- Parametrised, registered successor to the 6-bit 2:1 metric mux used in the Viterbi path-metric datapath.
- NCH independent channels, each W bits wide. Each channel either passes one of two candidate metrics selected by an external bit, or performs compare-select (minimum).
- Outputs carry a per-channel decision bit for traceback.
- Includes a one-stage valid/ready pipeline register and common-MSB metric normalisation.

Parameters:
- W, 6, metric width per channel (>=2)
- NCH, 4, number of channels (>=1)
- CNT_W, 8, width of normalisation event counter

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset
- mode  input  1  0 = external select (plain mux), 1 = compare-select (min); sampled with each accepted input
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept a beat this cycle
- d0  input  NCH*W  candidate 0 metrics; channel i at bits [i*W +: W]
- d1  input  NCH*W  candidate 1 metrics; same packing
- sel  input  NCH  per-channel select, used only when mode=0
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts output beat
- y  output  NCH*W  selected (and possibly normalised) metrics
- dec  output  NCH  per-channel decision: 1 = d1 chosen
- norm_cnt  output  CNT_W  number of normalised beats, saturating

Behaviour:
- Reset: reset_n low at a rising edge clears out_valid, y, dec and norm_cnt to 0. Reset overrides any transfer in the same cycle. A beat in flight is discarded.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready. The result is registered on that edge, so out_valid is high the next cycle (latency 1).
  - Full throughput: back-to-back accepts are possible while out_ready=1.
- Output hold: when out_valid && !out_ready, y, dec and out_valid hold stable and in_ready=0. Inputs are ignored.
- Drain: an output transfer (out_valid && out_ready) with no new accept clears out_valid the next cycle.
- Select, per channel i:
  - mode=0: dec[i]=sel[i], and r_i = sel[i] ? d1_i : d0_i.
  - mode=1: dec[i] = (d1_i < d0_i), unsigned. Tie chooses d0 (dec=0). r_i = min.
- Normalisation, applied on the accepted beat, combinationally before the register:
  - If the MSB (bit W-1) of every r_i is 1, each y_i = r_i with bit W-1 cleared (r_i - 2^(W-1)), and norm_cnt increments.
  - Otherwise y_i = r_i.
  - Applies in both modes.
- norm_cnt saturates at 2^CNT_W-1. It is unaffected by stalls and counts only accepted beats.
- No arithmetic wrap: the select is pure comparison, and normalisation only clears a bit that is known to be set.
- mode and sel only matter on accepting cycles. Changes while stalled have no effect.

Test Plan (W=6, NCH=4):
1. Reset: hold reset_n=0 for 2 clocks with in_valid=1 and random data -> out_valid=0, y=0, dec=0, norm_cnt=0, in_ready=1 after release.
2. Mux mode: mode=0, sel=4'b0101, d0 channels {10,20,30,40}, d1 {1,2,3,4} -> next cycle out_valid=1, y channels {1,20,3,40}, dec=4'b0101, norm_cnt=0.
3. Compare-select with tie: mode=1, d0 {5,9,33,12}, d1 {7,9,2,63} -> y {5,9,2,12}, dec=4'b0100.
4. Normalisation: mode=1, d0 {40,50,60,63}, d1 {45,33,61,32} -> y {8,1,28,0}, dec=4'b1010, norm_cnt=1. Repeat 300 such beats -> norm_cnt saturates at 255.
5. Backpressure: stream 3 beats with out_ready=0 from the second cycle -> first result held stable, in_ready=0, later beats not accepted until out_ready=1. Then all 3 results emerge in order with no loss or duplication.
6. Mid-stall reset: out_valid=1, out_ready=0, assert reset_n=0 for one clock -> out_valid=0, y=0, norm_cnt=0 on the next cycle. The held beat is never delivered.
